// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_busy_cell
//   One scoreboard bit. It is set when decode issues an instruction that
//   writes this register. It is cleared when the register file itself is
//   written. The two events never land on the same edge, because issue is
//   refused while the bit is set. Set is still given priority, so the cell
//   has a defined result if they ever did coincide.
//   clk_i  : clock
//   rst_i  : async active-high reset
//   set_i  : issue accepted for this register
//   clr_i  : register file write to this register this cycle
//   busy_o : register has an outstanding producer
// ----------------------------------------------------------------------------
module regfile_wb_busy_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic set_i,
    input  logic clr_i,
    output logic busy_o
);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      busy_o <= 1'b0;
        else if (set_i) busy_o <= 1'b1;
        else if (clr_i) busy_o <= 1'b0;
    end
endmodule

// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port between two write-back
//   requesters using round-robin arbitration. It also keeps a per-register
//   busy scoreboard that decode uses for RAW/WAW hazard detection.
//   Parameters: NUM_REGS (== 2**ADDR_W, r0 hard-wired zero), ADDR_W, DATA_W
//   Ports:
//     clk_i, rst_i                      clock, async active-high reset
//     reqN_valid_i/addr_i/data_i        write-back request, N = 0 (ALU), 1 (mem)
//     reqN_ready_o                      grant this cycle (combinational)
//     issue_valid_i/addr_i              decode issuing a writer of issue_addr_i
//     issue_ready_o                     destination not busy, issue accepted
//     rs_addr_i, rt_addr_i              decode source registers
//     hazard_o                          a source has a pending write
//     RegWrite_o/RDaddr_o/RDdata_o      registered register file write port
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    output logic              issue_ready_o,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic              hazard_o,
    output logic              RegWrite_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // rr_q == 0: req0 wins a tie next; rr_q == 1: req1 wins a tie next.
    logic          rr_q;
    logic          gnt0, gnt1;
    wb_req_t       sel;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_set;
    logic [NUM_REGS-1:0] busy_clr;
    logic          issue_fire;

    // ---------------- arbitration ----------------
    always_comb begin
        gnt0 = req0_valid_i && (!req1_valid_i || !rr_q);
        gnt1 = req1_valid_i && (!req0_valid_i ||  rr_q);
        sel  = gnt1 ? '{addr: req1_addr_i, data: req1_data_i}
                    : '{addr: req0_addr_i, data: req0_data_i};
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    // The pointer moves to whichever requester lost, so a requester that was
    // just served yields the next tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     rr_q <= 1'b0;
        else if (gnt0) rr_q <= 1'b1;
        else if (gnt1) rr_q <= 1'b0;
    end

    // ---------------- registered write port ----------------
    // A grant to r0 still consumes the request and loads addr/data, but it
    // never raises the write enable. With no grant, addr/data keep their
    // last value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            RegWrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
        end else if (gnt0 || gnt1) begin
            RegWrite_o <= (sel.addr != '0);
            RDaddr_o   <= sel.addr;
            RDdata_o   <= sel.data;
        end else begin
            RegWrite_o <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    assign issue_ready_o = (issue_addr_i == '0) || !busy[issue_addr_i];
    assign issue_fire    = issue_valid_i && issue_ready_o;

    // r0 never becomes busy.
    assign busy[0]     = 1'b0;
    assign busy_set[0] = 1'b0;
    assign busy_clr[0] = 1'b0;

    // Busy clears off the registered write port, not off the grant. This
    // keeps a register busy until the register file actually holds the new
    // value.
    for (genvar a = 1; a < NUM_REGS; a++) begin : g_busy
        assign busy_set[a] = issue_fire && (issue_addr_i == ADDR_W'(a));
        assign busy_clr[a] = RegWrite_o && (RDaddr_o == ADDR_W'(a));

        regfile_wb_busy_cell u_cell (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .set_i  (busy_set[a]),
            .clr_i  (busy_clr[a]),
            .busy_o (busy[a])
        );
    end

    assign hazard_o = ((rs_addr_i != '0) && busy[rs_addr_i]) ||
                      ((rt_addr_i != '0) && busy[rt_addr_i]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Each table row is one clock cycle.
// A row holds the inputs driven in that cycle. It also holds the outputs
// expected in that same cycle: combinational ones from the row's inputs,
// registered ones from the previous rows.
module tb_regfile_wb_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0, issue_valid_i = 1'b0;
    logic [4:0]  req0_addr_i = '0, req1_addr_i = '0, issue_addr_i = '0;
    logic [4:0]  rs_addr_i = '0, rt_addr_i = '0;
    logic [31:0] req0_data_i = '0, req1_data_i = '0;
    logic        req0_ready_o, req1_ready_o, issue_ready_o, hazard_o, RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;

    int checks = 0;
    int failures = 0;

    regfile_wb_arbiter #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i),
        .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i),
        .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
        .issue_valid_i(issue_valid_i), .issue_addr_i(issue_addr_i),
        .issue_ready_o(issue_ready_o),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .hazard_o(hazard_o),
        .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v0; logic [4:0] a0; logic [31:0] d0;
        logic        v1; logic [4:0] a1; logic [31:0] d1;
        logic        iv; logic [4:0] ia; logic [4:0] rs; logic [4:0] rt;
        logic        e_r0, e_r1, e_ir, e_hz, e_rw;
        logic        chk_wd;       // also compare RDaddr_o/RDdata_o
        logic [4:0]  e_ad; logic [31:0] e_da;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(
        input logic v0, input logic [4:0] a0, input logic [31:0] d0,
        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
        input logic iv, input logic [4:0] ia, input logic [4:0] rs, input logic [4:0] rt,
        input logic e_r0, input logic e_r1, input logic e_ir, input logic e_hz,
        input logic e_rw, input logic chk_wd, input logic [4:0] e_ad, input logic [31:0] e_da);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.iv = iv; v.ia = ia; v.rs = rs; v.rt = rt;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_ir = e_ir; v.e_hz = e_hz; v.e_rw = e_rw;
        v.chk_wd = chk_wd; v.e_ad = e_ad; v.e_da = e_da;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0_valid_i = v.v0; req0_addr_i = v.a0; req0_data_i = v.d0;
        req1_valid_i = v.v1; req1_addr_i = v.a1; req1_data_i = v.d1;
        issue_valid_i = v.iv; issue_addr_i = v.ia; rs_addr_i = v.rs; rt_addr_i = v.rt;
    endtask

    initial begin
        //                 v0 a0 d0            v1 a1 d1           iv ia  rs  rt   r0 r1 ir hz rw cw ad  da
        // both valid from reset: req0 first, then req1
        vecs[0]  = mk(1, 5, 32'h11,        1, 6, 32'h22,      0, 0,  0,  0,   1, 0, 1, 0, 0, 1, 0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,         1, 6, 32'h22,      0, 0,  0,  0,   0, 1, 1, 0, 1, 1, 5, 32'h11);
        // six cycles of continuous contention: 0,1,0,1,0,1
        vecs[2]  = mk(1, 1, 32'hA0,        1, 2, 32'hB0,      0, 0,  0,  0,   1, 0, 1, 0, 1, 1, 6, 32'h22);
        vecs[3]  = mk(1, 1, 32'hA1,        1, 2, 32'hB0,      0, 0,  0,  0,   0, 1, 1, 0, 1, 1, 1, 32'hA0);
        vecs[4]  = mk(1, 1, 32'hA1,        1, 2, 32'hB1,      0, 0,  0,  0,   1, 0, 1, 0, 1, 1, 2, 32'hB0);
        vecs[5]  = mk(1, 1, 32'hA2,        1, 2, 32'hB1,      0, 0,  0,  0,   0, 1, 1, 0, 1, 1, 1, 32'hA1);
        vecs[6]  = mk(1, 1, 32'hA2,        1, 2, 32'hB2,      0, 0,  0,  0,   1, 0, 1, 0, 1, 1, 2, 32'hB1);
        vecs[7]  = mk(1, 1, 32'hA3,        1, 2, 32'hB2,      0, 0,  0,  0,   0, 1, 1, 0, 1, 1, 1, 32'hA2);
        // scoreboard on r7: issue, WAW stall, write-back, hazard release
        vecs[8]  = mk(0, 0, 32'h0,         0, 0, 32'h0,       1, 7,  0,  0,   0, 0, 1, 0, 1, 1, 2, 32'hB2);
        vecs[9]  = mk(0, 0, 32'h0,         0, 0, 32'h0,       1, 7,  7,  0,   0, 0, 0, 1, 0, 1, 2, 32'hB2);
        vecs[10] = mk(0, 0, 32'h0,         1, 7, 32'h77,      0, 0,  7,  0,   0, 1, 1, 1, 0, 1, 2, 32'hB2);
        vecs[11] = mk(0, 0, 32'h0,         0, 0, 32'h0,       0, 0,  0,  7,   0, 0, 1, 1, 1, 1, 7, 32'h77);
        vecs[12] = mk(0, 0, 32'h0,         0, 0, 32'h0,       0, 7,  7,  7,   0, 0, 1, 0, 0, 1, 7, 32'h77);
        // write to r0 is consumed without a write; r0 is never busy
        vecs[13] = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 32'h0,       0, 0,  0,  0,   1, 0, 1, 0, 0, 1, 7, 32'h77);
        vecs[14] = mk(0, 0, 32'h0,         0, 0, 32'h0,       1, 0,  0,  0,   0, 0, 1, 0, 0, 0, 0, 32'h0);
        vecs[15] = mk(0, 0, 32'h0,         0, 0, 32'h0,       1, 0,  0,  0,   0, 0, 1, 0, 0, 0, 0, 32'h0);
        // rr==1 now: lone req1, then both -> req0
        vecs[16] = mk(0, 0, 32'h0,         1, 3, 32'h33,      0, 0,  0,  0,   0, 1, 1, 0, 0, 0, 0, 32'h0);
        vecs[17] = mk(1, 4, 32'h44,        1, 3, 32'h34,      0, 0,  0,  0,   1, 0, 1, 0, 1, 1, 3, 32'h33);
        vecs[18] = mk(0, 0, 32'h0,         1, 3, 32'h34,      0, 0,  0,  0,   0, 1, 1, 0, 1, 1, 4, 32'h44);
        vecs[19] = mk(0, 0, 32'h0,         0, 0, 32'h0,       0, 0,  0,  0,   0, 0, 1, 0, 1, 1, 3, 32'h34);
        vecs[20] = mk(0, 0, 32'h0,         0, 0, 32'h0,       0, 0,  0,  0,   0, 0, 1, 0, 0, 1, 3, 32'h34);

        // reset state
        #12;
        chk("rst_regwrite", 32'(RegWrite_o), 32'h0);
        chk("rst_rdaddr",   32'(RDaddr_o),   32'h0);
        chk("rst_rddata",   RDdata_o,        32'h0);
        rst_i = 1'b0;

        for (int i = 0; i < 21; i++) begin
            @(posedge clk_i); #1;
            drive(vecs[i]);
            #2;
            chk($sformatf("v%0d_rdy0", i),  32'(req0_ready_o),  32'(vecs[i].e_r0));
            chk($sformatf("v%0d_rdy1", i),  32'(req1_ready_o),  32'(vecs[i].e_r1));
            chk($sformatf("v%0d_issrdy", i), 32'(issue_ready_o), 32'(vecs[i].e_ir));
            chk($sformatf("v%0d_hazard", i), 32'(hazard_o),      32'(vecs[i].e_hz));
            chk($sformatf("v%0d_regwr", i), 32'(RegWrite_o),    32'(vecs[i].e_rw));
            if (vecs[i].chk_wd) begin
                chk($sformatf("v%0d_rdaddr", i), 32'(RDaddr_o), 32'(vecs[i].e_ad));
                chk($sformatf("v%0d_rddata", i), RDdata_o,      vecs[i].e_da);
            end
        end

        // async reset in the middle of a transfer
        @(posedge clk_i); #1;
        req0_valid_i = 1; req0_addr_i = 9; req0_data_i = 32'h99;
        req1_valid_i = 0; issue_valid_i = 1; issue_addr_i = 10; rs_addr_i = 10; rt_addr_i = 0;
        #2;
        chk("mr_pre_rdy0", 32'(req0_ready_o), 32'h1);
        chk("mr_pre_haz",  32'(hazard_o),     32'h0);
        @(posedge clk_i); #1;
        issue_valid_i = 0;
        #1;
        chk("mr_regwr",  32'(RegWrite_o), 32'h1);
        chk("mr_rdaddr", 32'(RDaddr_o),   32'h9);
        chk("mr_haz",    32'(hazard_o),   32'h1);
        chk("mr_issrdy", 32'(issue_ready_o), 32'h0);
        #1 rst_i = 1'b1;
        #1;
        chk("ar_regwr",  32'(RegWrite_o), 32'h0);
        chk("ar_rdaddr", 32'(RDaddr_o),   32'h0);
        chk("ar_rddata", RDdata_o,        32'h0);
        chk("ar_haz",    32'(hazard_o),   32'h0);
        chk("ar_issrdy", 32'(issue_ready_o), 32'h1);
        #1 rst_i = 1'b0;
        req1_valid_i = 1; req1_addr_i = 11; req1_data_i = 32'hBB;
        #1;
        chk("ar_rr_rdy0", 32'(req0_ready_o), 32'h1);
        chk("ar_rr_rdy1", 32'(req1_ready_o), 32'h0);
        @(posedge clk_i); #1;
        chk("ar_post_regwr",  32'(RegWrite_o), 32'h1);
        chk("ar_post_rdaddr", 32'(RDaddr_o),   32'h9);
        chk("ar_post_rddata", RDdata_o,        32'h99);
        chk("ar_post_rdy1",   32'(req1_ready_o), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
